// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: pipeline payload types, CSR port types, exception codes
// and RV32I opcode constants shared by the decode queue and its decoder.
package decode_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [11:0] csr_addr_t;

    // Synchronous exception cause codes
    typedef enum logic [3:0] {
        INSTRUCTION_MISALIGNED   = 4'd0,
        INSTRUCTION_ACCESS_FAULT = 4'd1,
        ILLEGAL_INSTRUCTION      = 4'd2,
        BREAKPOINT               = 4'd3,
        LOAD_MISALIGNED          = 4'd4,
        LOAD_ACCESS_FAULT        = 4'd5,
        STORE_MISALIGNED         = 4'd6,
        STORE_ACCESS_FAULT       = 4'd7,
        ECALL_M                  = 4'd11
    } exception_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    // RV32I major opcodes
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        word_t      pc;
        word_t      raw_instr;
        logic       valid;
        logic       is_exception;
        exception_t exception;
    } fetch_data_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        csr_addr_t  csr;
        logic       is_exception;
        exception_t exception;
    } control_t;

    typedef struct packed {
        word_t      pc;
        word_t      raw_instr;
        logic       valid;
        control_t   ctl;
        creg_addr_t dst;
        word_t      srca;
        word_t      srcb;
        word_t      csr_data;
    } decode_data_t;

    typedef struct packed {
        logic      valid;
        logic      w_valid;
        csr_addr_t ra;
        csr_addr_t wa;
        word_t     wd;
    } csr_input_t;

    typedef struct packed {
        word_t rd;
    } csr_output_t;

    // Map funct3 (plus the funct7[5] alternate bit) onto an ALU operation
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push handshake, decode-side pop handshake and
// the pipeline flush, bundled between the queue and its neighbours.
interface decode_queue_if;
    import decode_queue_pkg::*;

    logic         in_valid;
    logic         in_ready;
    fetch_data_t  dataF;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    decode_data_t dataD;

    // Pipeline side: offers fetched entries, consumes decoded ones
    modport master (
        output in_valid, dataF, flush, out_ready,
        input  in_ready, out_valid, dataD
    );

    // Queue side
    modport slave (
        input  in_valid, dataF, flush, out_ready,
        output in_ready, out_valid, dataD
    );

endinterface

// File: rtl/decode_queue_decoder.sv
// decode_queue_decoder: purely combinational RV32I decoder producing the
// control word and an illegal-encoding flag for one raw instruction.
module decode_queue_decoder
    import decode_queue_pkg::*;
(
    input  word_t    instr,
    output control_t ctl,
    output logic     is_exception
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Classify the opcode, derive control bits and flag malformed encodings
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        ctl           = '0;
        ctl.alu_op    = ALU_ADD;
        ctl.exception = ILLEGAL_INSTRUCTION;
        is_exception  = 1'b0;

        case (opcode)
            OP_LUI: begin
                ctl.alu_op    = ALU_PASS_B;
                ctl.use_imm   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctl.use_imm   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            OP_JAL: begin
                ctl.jump      = 1'b1;
                ctl.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctl.jump      = 1'b1;
                ctl.use_imm   = 1'b1;
                ctl.reg_write = 1'b1;
                is_exception  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                ctl.branch   = 1'b1;
                ctl.alu_op   = ALU_SUB;
                is_exception = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                ctl.mem_read  = 1'b1;
                ctl.use_imm   = 1'b1;
                ctl.reg_write = 1'b1;
                is_exception  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                ctl.mem_write = 1'b1;
                ctl.use_imm   = 1'b1;
                is_exception  = (funct3 > 3'b010);
            end
            OP_IMM: begin
                ctl.use_imm   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && instr[30]);
                if (funct3 == 3'b001) begin
                    is_exception = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    is_exception = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OP_REG: begin
                ctl.reg_write = 1'b1;
                ctl.alu_op    = alu_from_funct(funct3, instr[30]);
                is_exception  = !((funct7 == 7'h00) ||
                                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_MISC_MEM: begin
                ctl.alu_op = ALU_ADD;
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    // ecall / ebreak / xret / wfi carry no register operands
                    is_exception = (instr[19:15] != 5'd0) || (instr[11:7] != 5'd0);
                end else if (funct3 == 3'b100) begin
                    is_exception = 1'b1;
                end else begin
                    ctl.csr       = instr[31:20];
                    ctl.reg_write = 1'b1;
                end
            end
            default: begin
                is_exception = 1'b1;
            end
        endcase

        ctl.is_exception = is_exception;
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry circular buffer between fetch and execute; the
// head entry is decoded combinationally and presented with its register and
// CSR read data.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    decode_queue_if.slave    bus,
    output creg_addr_t       ra1,
    output creg_addr_t       ra2,
    input  word_t            rd1,
    input  word_t            rd2,
    output csr_input_t       csr_input,
    input  csr_output_t      csr_output,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    fetch_data_t      mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        out_valid;
    fetch_data_t head;
    control_t    dec_ctl;
    logic        dec_exc;
    control_t    ctl;
    decode_data_t data_d;

    // Full blocks pushes even when a pop happens in the same cycle, so an
    // entry never passes straight through a full queue.
    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign out_valid = !empty && !bus.flush;
    assign push      = bus.in_valid && !full;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid;
    assign count         = cnt;

    // Pointer and occupancy update: reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers and count alone decide which entries are live.
        if (push) begin
            mem[wr_ptr] <= bus.dataF;
        end
    end

    assign head = mem[rd_ptr];

    decode_queue_decoder u_decoder (
        .instr        (head.raw_instr),
        .ctl          (dec_ctl),
        .is_exception (dec_exc)
    );

    // Exception resolution: a fetch fault wins over a decode-detected illegal
    // instruction, and an all-zero bubble is never illegal.
    always_comb begin
        ctl              = dec_ctl;
        ctl.is_exception = 1'b0;
        ctl.exception    = head.exception;
        if (head.is_exception) begin
            ctl.is_exception = 1'b1;
        end else if (dec_exc && (head.raw_instr != '0)) begin
            ctl.is_exception = 1'b1;
            ctl.exception    = ILLEGAL_INSTRUCTION;
        end
    end

    assign ra1 = head.raw_instr[19:15];
    assign ra2 = head.raw_instr[24:20];

    // Assemble the decoded head entry with its operand and CSR read data
    always_comb begin
        data_d           = '0;
        data_d.pc        = head.pc;
        data_d.raw_instr = head.raw_instr;
        data_d.valid     = head.valid;
        data_d.ctl       = ctl;
        data_d.dst       = head.raw_instr[11:7];
        data_d.srca      = rd1;
        data_d.srcb      = rd2;
        data_d.csr_data  = csr_output.rd;
    end

    assign bus.dataD = data_d;

    // CSR read request for the head; writes are issued later in the pipe
    always_comb begin
        csr_input         = '0;
        csr_input.valid   = (ctl.csr != '0) && out_valid;
        csr_input.w_valid = 1'b0;
        csr_input.ra      = ctl.csr;
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the decode queue.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH     = 4;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int NUM_INSTR = 10;

    typedef struct packed {
        fetch_data_t f;
        logic        illegal;   // encoding is not a valid RV32I instruction
        csr_addr_t   csr;       // CSR address named by the instruction, 0 if none
    } entry_t;

    logic             clk = 1'b0;
    logic             reset;
    creg_addr_t       ra1;
    creg_addr_t       ra2;
    word_t            rd1;
    word_t            rd2;
    csr_input_t       csr_input;
    csr_output_t      csr_output;
    logic [CNT_W-1:0] count;

    decode_queue_if bus ();

    decode_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .csr_input  (csr_input),
        .csr_output (csr_output),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Register file and CSR file stand-ins: data is a tagged copy of the address
    assign rd1           = 32'h1000_0000 | 32'(ra1);
    assign rd2           = 32'h2000_0000 | 32'(ra2);
    assign csr_output.rd = 32'hC500_0000 | 32'(csr_input.ra);

    entry_t model_q[$];
    entry_t cur_entry;
    int     checks   = 0;
    int     failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-assembled instruction table with known legality and CSR target
    function automatic void instr_info(input int idx, output word_t raw,
                                       output logic illegal, output csr_addr_t csr);
        illegal = 1'b0;
        csr     = 12'h000;
        case (idx)
            0: raw = 32'h0051_0093;                  // addi x1, x2, 5
            1: raw = 32'h0052_01B3;                  // add  x3, x4, x5
            2: raw = 32'h0083_A303;                  // lw   x6, 8(x7)
            3: raw = 32'h0020_8463;                  // beq  x1, x2, +8
            4: begin raw = 32'h3000_22F3; csr = 12'h300; end  // csrrs x5, mstatus, x0
            5: begin raw = 32'h3055_1073; csr = 12'h305; end  // csrrw x0, mtvec, x10
            6: raw = 32'h0000_0073;                  // ecall
            7: begin raw = 32'hFFFF_FFFF; illegal = 1'b1; end
            8: begin raw = 32'h0000_0002; illegal = 1'b1; end
            default: begin raw = 32'h0000_0000; illegal = 1'b1; end  // bubble
        endcase
    endfunction

    function automatic entry_t make_entry(input int idx, input word_t pc,
                                          input logic fexc, input exception_t code);
        entry_t    e;
        word_t     raw;
        logic      ill;
        csr_addr_t csr;
        instr_info(idx, raw, ill, csr);
        e.f.pc           = pc;
        e.f.raw_instr    = raw;
        e.f.valid        = 1'b1;
        e.f.is_exception = fexc;
        e.f.exception    = code;
        e.illegal        = ill;
        e.csr            = csr;
        return e;
    endfunction

    task automatic set_in(input logic v, input entry_t e);
        bus.in_valid = v;
        bus.dataF    = e.f;
        cur_entry    = e;
    endtask

    task automatic check_head(input entry_t e, input logic exp_ov);
        word_t      raw;
        logic       exp_exc;
        exception_t exp_code;
        raw      = e.f.raw_instr;
        exp_exc  = e.f.is_exception || (e.illegal && (raw != 32'h0));
        exp_code = e.f.is_exception ? e.f.exception : ILLEGAL_INSTRUCTION;
        check("pc",        64'(bus.dataD.pc),        64'(e.f.pc));
        check("raw_instr", 64'(bus.dataD.raw_instr), 64'(raw));
        check("valid",     64'(bus.dataD.valid),     64'(e.f.valid));
        check("dst",       64'(bus.dataD.dst),       64'(raw[11:7]));
        check("ra1",       64'(ra1),                 64'(raw[19:15]));
        check("ra2",       64'(ra2),                 64'(raw[24:20]));
        check("srca",      64'(bus.dataD.srca),      64'(32'h1000_0000 | 32'(raw[19:15])));
        check("srcb",      64'(bus.dataD.srcb),      64'(32'h2000_0000 | 32'(raw[24:20])));
        check("ctl_csr",   64'(bus.dataD.ctl.csr),   64'(e.csr));
        check("csr_data",  64'(bus.dataD.csr_data),  64'(32'hC500_0000 | 32'(e.csr)));
        check("is_exc",    64'(bus.dataD.ctl.is_exception), 64'(exp_exc));
        if (exp_exc) begin
            check("exc_code", 64'(bus.dataD.ctl.exception), 64'(exp_code));
        end
        check("csr_valid",   64'(csr_input.valid),   64'((e.csr != 12'h0) && exp_ov));
        check("csr_ra",      64'(csr_input.ra),      64'(e.csr));
        check("csr_w_valid", 64'(csr_input.w_valid), 64'(0));
    endtask

    task automatic check_all();
        int   n;
        logic exp_ov;
        n      = model_q.size();
        exp_ov = (n != 0) && !bus.flush;
        check("count",     64'(count),         64'(n));
        check("in_ready",  64'(bus.in_ready),  64'(n != DEPTH));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (n != 0) begin
            check_head(model_q[0], exp_ov);
        end else begin
            check("csr_valid_empty", 64'(csr_input.valid), 64'(0));
        end
    endtask

    // One clock: predict the transfer from current inputs, then compare
    task automatic cycle();
        logic do_push;
        logic do_pop;
        do_push = bus.in_valid && (model_q.size() != DEPTH);
        do_pop  = bus.out_ready && (model_q.size() != 0) && !bus.flush;
        @(posedge clk);
        if (reset || bus.flush) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                model_q.delete(0);
            end
            if (do_push) begin
                model_q.push_back(cur_entry);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, make_entry(0, 32'h0, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        cycle();
        reset = 1'b0;

        // Three pushes with execute stalled; head must hold the first pc
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, make_entry(i, 32'h8000_0000 + 32'(4 * i), 1'b0, INSTRUCTION_MISALIGNED));
            cycle();
        end
        set_in(1'b0, cur_entry);
        repeat (3) cycle();
        check("hold_count", 64'(count), 64'(3));
        check("hold_pc",    64'(bus.dataD.pc), 64'(32'h8000_0000));

        // Fill to capacity, then offer push and pop together while full
        set_in(1'b1, make_entry(3, 32'h8000_000C, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        set_in(1'b1, make_entry(1, 32'h8000_0010, 1'b0, INSTRUCTION_MISALIGNED));
        bus.out_ready = 1'b1;
        cycle();
        check("full_pushpop_count", 64'(count), 64'(3));
        check("full_pushpop_head",  64'(bus.dataD.pc), 64'(32'h8000_0004));
        cycle();
        check("pushpop_count", 64'(count), 64'(3));
        check("pushpop_head",  64'(bus.dataD.pc), 64'(32'h8000_0008));
        set_in(1'b0, cur_entry);
        repeat (4) cycle();
        check("drained_count", 64'(count), 64'(0));

        // Streaming push/pop pairs walk the pointers around several times
        for (int i = 0; i <= 10; i++) begin
            set_in(1'b1, make_entry(i % 7, 32'h8000_0000 + 32'(4 * i), 1'b0, INSTRUCTION_MISALIGNED));
            cycle();
            check("wrap_pc", 64'(bus.dataD.pc), 64'(32'h8000_0000 + 32'(4 * i)));
        end
        set_in(1'b0, cur_entry);
        cycle();

        // Flush with three entries queued and a push on the same cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, make_entry((i == 0) ? 4 : i, 32'h9000_0000 + 32'(4 * i), 1'b0, INSTRUCTION_MISALIGNED));
            cycle();
        end
        check("pre_flush_csr_valid", 64'(csr_input.valid), 64'(1));
        bus.flush = 1'b1;
        set_in(1'b1, make_entry(0, 32'h9000_0100, 1'b0, INSTRUCTION_MISALIGNED));
        #1;
        check("flush_out_valid_comb", 64'(bus.out_valid), 64'(0));
        check("flush_csr_valid_comb", 64'(csr_input.valid), 64'(0));
        cycle();
        bus.flush = 1'b0;
        set_in(1'b0, cur_entry);
        #1;
        check("post_flush_count",     64'(count), 64'(0));
        check("post_flush_out_valid", 64'(bus.out_valid), 64'(0));

        // Fetch fault outranks an illegal encoding
        set_in(1'b1, make_entry(7, 32'hA000_0000, 1'b1, INSTRUCTION_MISALIGNED));
        cycle();
        check("fetch_exc_flag", 64'(bus.dataD.ctl.is_exception), 64'(1));
        check("fetch_exc_code", 64'(bus.dataD.ctl.exception), 64'(INSTRUCTION_MISALIGNED));
        set_in(1'b0, cur_entry);
        bus.out_ready = 1'b1;
        cycle();
        // Bubble is never illegal
        bus.out_ready = 1'b0;
        set_in(1'b1, make_entry(9, 32'hA000_0004, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        check("bubble_no_exc", 64'(bus.dataD.ctl.is_exception), 64'(0));
        set_in(1'b0, cur_entry);
        bus.out_ready = 1'b1;
        cycle();
        // Illegal encoding without a fetch fault
        bus.out_ready = 1'b0;
        set_in(1'b1, make_entry(7, 32'hA000_0008, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        check("illegal_code", 64'(bus.dataD.ctl.exception), 64'(ILLEGAL_INSTRUCTION));
        set_in(1'b0, cur_entry);
        bus.out_ready = 1'b1;
        cycle();

        // Reset mid-stream discards queued entries
        bus.out_ready = 1'b0;
        set_in(1'b1, make_entry(0, 32'hB000_0000, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        cycle();
        set_in(1'b0, cur_entry);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_count",    64'(count), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        // csrr at the head requests a CSR read
        set_in(1'b1, make_entry(4, 32'hB000_0010, 1'b0, INSTRUCTION_MISALIGNED));
        cycle();
        set_in(1'b0, cur_entry);
        #1;
        check("csrr_valid", 64'(csr_input.valid), 64'(1));
        check("csrr_ra",    64'(csr_input.ra), 64'(12'h300));
        bus.out_ready = 1'b1;
        cycle();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            entry_t     e;
            int         idx;
            logic       fexc;
            exception_t code;
            idx  = $urandom_range(0, NUM_INSTR - 1);
            fexc = ($urandom_range(0, 3) == 0);
            code = ($urandom_range(0, 1) == 0) ? INSTRUCTION_MISALIGNED : INSTRUCTION_ACCESS_FAULT;
            e    = make_entry(idx, $urandom(), fexc, code);
            e.f.valid = 1'($urandom_range(0, 1));
            set_in(1'($urandom_range(0, 1)), e);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 63) == 0);
            #1;
            check_all();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
